router_input_port: RTL and testbench

- Per-direction input stage of the 2x2 mesh router.
- Buffers incoming flits in a small FIFO and decodes each packet header: flit type, 12-bit packet length and XY route.
- Drives a one-hot request toward the output-port arbiters, plus the flit_type/length pair their packet timers consume.
- Holds the route from HEADER until the TAIL flit is popped.

---
 rtl/router_input_port.sv | 130 +++++++++++++
 tb/tb_router_input_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// Mesh router input stage: flit FIFO, header decode and XY route request.
// The route is held from HEADER acceptance until the TAIL flit is popped.
module router_input_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CUR_X      = 1,
    parameter int CUR_Y      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    flit_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    flit_out,
    output logic [2:0]               flit_type,
    output logic [11:0]              length,
    output logic [4:0]               req,
    output logic                     err_drop,
    output logic                     dbg_state_o,
    output logic [$clog2(DEPTH):0]   dbg_count_o
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a flit transfers on a rising edge where valid_in && ready_out;
    // a pop happens on an edge where rd_en is high while req is non-zero.
    typedef enum logic {
        IDLE   = 1'b0,
        ROUTED = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    state_t                state_q, state_d;
    logic [4:0]            route_q, route_d, route_c;
    logic [11:0]           length_q, length_d;
    logic                  err_drop_q, err_drop_d;
    logic                  full, empty, push, pop, auto_pop, routed_pop;
    logic                  dest_x, dest_y;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = valid_in && !full;
    assign ready_out = !full;
    assign flit_out  = mem_q[rd_ptr_q];
    assign flit_type = empty ? 3'b000 : flit_out[31:29];
    assign dest_x    = flit_out[16];
    assign dest_y    = flit_out[15];
    assign length    = length_q;
    assign err_drop  = err_drop_q;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

    // XY routing: resolve X first, then Y; one-hot {L,N,E,S,W}.
    always_comb begin
        route_c = 5'b10000;
        if (dest_x > 1'(CUR_X))      route_c = 5'b00100;
        else if (dest_x < 1'(CUR_X)) route_c = 5'b00001;
        else if (dest_y > 1'(CUR_Y)) route_c = 5'b00010;
        else if (dest_y < 1'(CUR_Y)) route_c = 5'b01000;
    end

    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        length_d   = length_q;
        auto_pop   = 1'b0;
        routed_pop = 1'b0;
        req        = 5'b00000;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (flit_out[29]) begin
                        state_d  = ROUTED;
                        route_d  = route_c;
                        length_d = flit_out[28:17];
                    end else begin
                        auto_pop = 1'b1;
                    end
                end
            end
            ROUTED: begin
                if (!empty) begin
                    req = route_q;
                    if (rd_en) begin
                        routed_pop = 1'b1;
                        if (flit_out[31]) begin
                            state_d = IDLE;
                            route_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop        = auto_pop || routed_pop;
    assign err_drop_d = auto_pop;
    assign wr_ptr_d   = wr_ptr_q + AW'(push);
    assign rd_ptr_d   = rd_ptr_q + AW'(pop);
    assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            route_q    <= '0;
            length_q   <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            route_q    <= route_d;
            length_q   <= length_d;
            err_drop_q <= err_drop_d;
        end
    end

    // Storage needs no reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_in;
    end
endmodule

// File: tb/tb_router_input_port.sv
// Randomized and directed bench for router_input_port against a queue-based
// packet model that tracks buffered flits, routing state and drop pulses.
module tb_router_input_port;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CUR_X = 1;
    localparam int CUR_Y = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] flit_in = '0;
    logic          valid_in = 1'b0;
    logic          rd_en = 1'b0;
    logic          ready_out;
    logic [DW-1:0] flit_out;
    logic [2:0]    flit_type;
    logic [11:0]   length;
    logic [4:0]    req;
    logic          err_drop;
    logic          dbg_state_o;
    logic [2:0]    dbg_count_o;

    router_input_port #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .CUR_X(CUR_X), .CUR_Y(CUR_Y)
    ) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
        .ready_out(ready_out), .rd_en(rd_en), .flit_out(flit_out),
        .flit_type(flit_type), .length(length), .req(req),
        .err_drop(err_drop), .dbg_state_o(dbg_state_o),
        .dbg_count_o(dbg_count_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    bit            m_routed;
    logic [4:0]    m_route;
    logic [11:0]   m_len;
    logic          m_err;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_route(input logic dx, input logic dy);
        int x = int'(dx);
        int y = int'(dy);
        if (x > CUR_X) return 5'b00100;
        if (x < CUR_X) return 5'b00001;
        if (y > CUR_Y) return 5'b00010;
        if (y < CUR_Y) return 5'b01000;
        return 5'b10000;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [2:0] t, input int len, input logic dx, input logic dy);
        logic [14:0] low = 15'($urandom);
        return {t, 12'(len), dx, dy, low};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_routed = 0;
        m_route  = '0;
        m_len    = '0;
        m_err    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input logic r, input logic v, input logic [DW-1:0] f, input logic rd);
        logic [DW-1:0] head;
        bit was_full;
        if (r) begin
            model_reset();
            return;
        end
        was_full = (exp_q.size() == DEPTH);
        m_err = 1'b0;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (m_routed) begin
                if (rd) begin
                    void'(exp_q.pop_front());
                    if (head[31]) begin
                        m_routed = 0;
                        m_route  = '0;
                    end
                end
            end else if (head[29]) begin
                m_routed = 1;
                m_route  = ref_route(head[16], head[15]);
                m_len    = head[28:17];
            end else begin
                void'(exp_q.pop_front());
                m_err = 1'b1;
            end
        end
        if (v && !was_full) exp_q.push_back(f);
    endtask

    task automatic check_outputs();
        bit emp = (exp_q.size() == 0);
        logic [DW-1:0] head = emp ? '0 : exp_q[0];
        check_eq("ready_out", 32'(ready_out), 32'(exp_q.size() < DEPTH));
        check_eq("count", 32'(dbg_count_o), 32'(exp_q.size()));
        check_eq("flit_type", 32'(flit_type), emp ? 32'd0 : 32'(head[31:29]));
        if (!emp) check_eq("flit_out", flit_out, head);
        check_eq("req", 32'(req), (m_routed && !emp) ? 32'(m_route) : 32'd0);
        check_eq("length", 32'(length), 32'(m_len));
        check_eq("err_drop", 32'(err_drop), 32'(m_err));
        check_eq("state", 32'(dbg_state_o), 32'(m_routed));
    endtask

    task automatic step(input logic r, input logic v, input logic [DW-1:0] f, input logic rd);
        rst = r; valid_in = v; flit_in = f; rd_en = rd;
        @(posedge clk);
        model_edge(r, v, f, rd);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rd);
    endtask

    function automatic logic [DW-1:0] rand_flit();
        int sel = $urandom_range(0, 9);
        logic [2:0] t;
        if (sel <= 2)      t = 3'b001;
        else if (sel <= 5) t = 3'b010;
        else if (sel <= 7) t = 3'b100;
        else if (sel == 8) t = 3'b101;
        else               t = 3'($urandom);
        return mk(t, $urandom_range(0, 4095), 1'($urandom), 1'($urandom));
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        step(1'b1, 1'b0, '0, 1'b0);
        check_eq("rst_ready", 32'(ready_out), 32'd1);
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_ftype", 32'(flit_type), 32'd0);

        // 3-flit packet to local port, rd_en held high throughout
        step(1'b0, 1'b1, mk(3'b001, 3, 1'b1, 1'b0), 1'b1);
        check_eq("pkt1_req_early", 32'(req), 32'd0);
        step(1'b0, 1'b1, mk(3'b010, 0, 1'b0, 1'b0), 1'b1);
        check_eq("pkt1_req_L", 32'(req), 32'h10);
        check_eq("pkt1_len", 32'(length), 32'd3);
        step(1'b0, 1'b1, mk(3'b100, 0, 1'b0, 1'b0), 1'b1);
        idle(2, 1'b1);
        check_eq("pkt1_req_done", 32'(req), 32'd0);
        idle(2, 1'b1);

        // Single-flit packets toward W and S
        step(1'b0, 1'b1, mk(3'b101, 9, 1'b0, 1'b1), 1'b0);
        idle(1, 1'b0);
        check_eq("req_W", 32'(req), 32'h01);
        idle(1, 1'b1);
        step(1'b0, 1'b1, mk(3'b101, 10, 1'b1, 1'b1), 1'b0);
        idle(1, 1'b0);
        check_eq("req_S", 32'(req), 32'h02);
        idle(2, 1'b1);

        // Fill the FIFO, then a push against full with a simultaneous pop
        step(1'b0, 1'b1, mk(3'b001, 4, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(3'b010, 0, 1'b0, 1'b0), 1'b0);
        check_eq("full_ready", 32'(ready_out), 32'd0);
        step(1'b0, 1'b1, mk(3'b100, 0, 1'b0, 1'b0), 1'b1);
        check_eq("full_pop_ready", 32'(ready_out), 32'd1);
        check_eq("full_pop_count", 32'(dbg_count_o), 32'd3);
        step(1'b0, 1'b1, mk(3'b100, 0, 1'b0, 1'b0), 1'b1);
        idle(5, 1'b1);

        // Stray payload while idle is dropped, then a header routes normally
        step(1'b0, 1'b1, mk(3'b010, 0, 1'b1, 1'b1), 1'b0);
        idle(1, 1'b0);
        check_eq("drop_pulse", 32'(err_drop), 32'd1);
        check_eq("drop_count", 32'(dbg_count_o), 32'd0);
        idle(1, 1'b0);
        check_eq("drop_pulse_end", 32'(err_drop), 32'd0);
        step(1'b0, 1'b1, mk(3'b101, 11, 1'b1, 1'b0), 1'b0);
        idle(1, 1'b0);
        check_eq("after_drop_req", 32'(req), 32'h10);
        idle(2, 1'b1);

        // Back-to-back packets with different routes and lengths
        step(1'b0, 1'b1, mk(3'b001, 5, 1'b0, 1'b1), 1'b1);
        step(1'b0, 1'b1, mk(3'b100, 0, 1'b0, 1'b0), 1'b1);
        step(1'b0, 1'b1, mk(3'b001, 7, 1'b1, 1'b1), 1'b1);
        step(1'b0, 1'b1, mk(3'b100, 0, 1'b0, 1'b0), 1'b1);
        idle(6, 1'b1);
        check_eq("b2b_len", 32'(length), 32'd7);

        // Reset mid-packet with two flits buffered
        step(1'b0, 1'b1, mk(3'b001, 2, 1'b0, 1'b0), 1'b0);
        step(1'b0, 1'b1, mk(3'b010, 0, 1'b0, 1'b0), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check_eq("mid_rst_req", 32'(req), 32'd0);
        check_eq("mid_rst_ready", 32'(ready_out), 32'd1);
        check_eq("mid_rst_ftype", 32'(flit_type), 32'd0);
        step(1'b0, 1'b1, mk(3'b101, 1, 1'b1, 1'b1), 1'b0);
        idle(1, 1'b0);
        check_eq("post_rst_req", 32'(req), 32'h02);
        idle(2, 1'b1);

        // Random traffic, including malformed streams and occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                 rand_flit(), ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
